// File: rtl/uart_pkg.sv
// Shared line convention and state encoding for the uart_tx / uart_rx pair.
// Line: idle low, start high, data bits inverted LSB first, stop low.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = LINE_IDLE;

    // Data bits travel inverted; the receiver applies the same function to recover them.
    function automatic logic line_bit(input logic d);
        return ~d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample strobe counter: counts samp_clk strobes while enabled and flags
// the strobe on which the count wraps, i.e. the end of one bit period.
module uart_bit_timer #(
    parameter int Oversample = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_samp,
    output logic o_period_end
);

    logic [Oversample-1:0] r_ticks;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_ticks <= '0;
        end else if (i_en && i_samp) begin
            r_ticks <= r_ticks + 1'b1;
        end
    end

    assign o_period_end = i_en && i_samp && (r_ticks == '1);

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter, one byte per valid/ready handshake, bit timing from samp_clk.
// Optional UART_TX_HOLD_EN adds a one-byte holding register for back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int Oversample = 3,
    parameter int StopBits   = 1
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       samp_clk,
    input  logic [7:0] in,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       bit_clk,
    output logic       out
);

    uart_state_e r_state;
    uart_state_e w_state_nxt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;
    logic        r_stopcnt;
    logic        r_out;
    logic        r_bit_clk;
    logic        w_out_nxt;
    logic        w_bit_clk_nxt;

    logic        w_accept;
    logic        w_timing;
    logic        w_period_end;
    logic        w_last_stop;
    logic        w_frame_end;
    logic        w_idle_load;
    logic        w_launch_hold;
    logic [7:0]  w_load_byte;

    assign w_accept    = valid && ready;
    assign w_timing    = (r_state == START) || (r_state == DATA) || (r_state == STOP);
    assign w_last_stop = (StopBits == 1) ? 1'b1 : r_stopcnt;
    assign w_frame_end = (r_state == STOP) && w_period_end && w_last_stop;
    assign busy        = (r_state != IDLE);
    assign bit_clk     = r_bit_clk;
    assign out         = r_out;

`ifdef UART_TX_HOLD_EN
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic       w_hold_fill;
    logic       w_hold_take;

    assign ready         = ~r_hold_full;
    assign w_launch_hold = r_hold_full;
    assign w_idle_load   = r_hold_full || w_accept;
    assign w_load_byte   = r_hold_full ? r_hold : in;
    // Bytes accepted outside IDLE park in hold; a fill on the take edge wins and refills it.
    assign w_hold_fill   = w_accept && (r_state != IDLE);
    assign w_hold_take   = r_hold_full && (((r_state == IDLE)) || w_frame_end);

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_hold_fill) begin
            r_hold      <= in;
            r_hold_full <= 1'b1;
        end else if (w_hold_take) begin
            r_hold_full <= 1'b0;
        end
    end
`else
    assign ready         = (r_state == IDLE);
    assign w_launch_hold = 1'b0;
    assign w_idle_load   = w_accept;
    assign w_load_byte   = in;
`endif

    // Counter held clear through IDLE/ARM so the start-bit strobe is tick 0.
    uart_bit_timer #(.Oversample(Oversample)) u_timer (
        .i_clk        (ref_clk),
        .i_reset      (reset),
        .i_clr        (~w_timing),
        .i_en         (w_timing),
        .i_samp       (samp_clk),
        .o_period_end (w_period_end)
    );

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_idle_load) w_state_nxt = ARM;
            ARM:     if (samp_clk) w_state_nxt = START;
            START:   if (w_period_end) w_state_nxt = DATA;
            DATA:    if (w_period_end && (r_bitcnt == 3'd7)) w_state_nxt = STOP;
            STOP:    if (w_frame_end) w_state_nxt = w_launch_hold ? START : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_out_nxt     = r_out;
        w_bit_clk_nxt = 1'b0;
        case (r_state)
            IDLE: w_out_nxt = LINE_IDLE;
            ARM: begin
                if (samp_clk) begin
                    w_out_nxt     = LINE_START;
                    w_bit_clk_nxt = 1'b1;
                end
            end
            START: begin
                if (w_period_end) begin
                    w_out_nxt     = line_bit(r_shift[0]);
                    w_bit_clk_nxt = 1'b1;
                end
            end
            DATA: begin
                if (w_period_end) begin
                    w_out_nxt     = (r_bitcnt == 3'd7) ? LINE_STOP : line_bit(r_shift[1]);
                    w_bit_clk_nxt = 1'b1;
                end
            end
            STOP: begin
                if (w_frame_end) begin
                    w_out_nxt     = w_launch_hold ? LINE_START : LINE_IDLE;
                    w_bit_clk_nxt = 1'b1;
                end
            end
            default: w_out_nxt = LINE_IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_out     <= LINE_IDLE;
            r_bit_clk <= 1'b0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
        end else begin
            r_out     <= w_out_nxt;
            r_bit_clk <= w_bit_clk_nxt;
            case (r_state)
                IDLE: if (w_idle_load) r_shift <= w_load_byte;
                START: if (w_period_end) r_bitcnt <= '0;
                DATA: begin
                    if (w_period_end) begin
                        r_shift   <= r_shift >> 1;
                        r_bitcnt  <= r_bitcnt + 1'b1;
                        r_stopcnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (w_period_end) begin
                        r_stopcnt <= r_stopcnt + 1'b1;
                        if (w_frame_end && w_launch_hold) r_shift <= w_load_byte;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8 ref_clk per samp_clk strobe, 64 ref_clk per bit.
// A second instance exercises StopBits=2.
module tb_uart_tx;

    logic       ref_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       samp_clk = 1'b0;
    logic [7:0] in1 = '0, in2 = '0;
    logic       valid1 = 1'b0, valid2 = 1'b0;
    logic       ready1, busy1, bclk1, out1;
    logic       ready2, busy2, bclk2, out2;
    logic       sel = 1'b0;
    logic       m_out, m_busy, m_bclk, m_ready;
    int         n_chk = 0;
    int         n_err = 0;
    int         sc = 0;

    uart_tx #(.Oversample(3), .StopBits(1)) dut (
        .ref_clk(ref_clk), .reset(reset), .samp_clk(samp_clk), .in(in1), .valid(valid1),
        .ready(ready1), .busy(busy1), .bit_clk(bclk1), .out(out1)
    );

    uart_tx #(.Oversample(3), .StopBits(2)) dut2 (
        .ref_clk(ref_clk), .reset(reset), .samp_clk(samp_clk), .in(in2), .valid(valid2),
        .ready(ready2), .busy(busy2), .bit_clk(bclk2), .out(out2)
    );

    assign m_out   = sel ? out2   : out1;
    assign m_busy  = sel ? busy2  : busy1;
    assign m_bclk  = sel ? bclk2  : bclk1;
    assign m_ready = sel ? ready2 : ready1;

    always #5 ref_clk = ~ref_clk;

    // Strobe updated just after the edge so it is stable for the next edge.
    always @(posedge ref_clk) begin
        #1;
        sc = (sc + 1) % 8;
        samp_clk = (sc == 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // Present a byte so that acceptance coincides with a strobe edge.
    task automatic send(input logic [7:0] b);
        int w = 0;
        while (!samp_clk && w < 20) begin
            @(negedge ref_clk);
            w++;
        end
        if (sel) begin in2 = b; valid2 = 1'b1; end
        else     begin in1 = b; valid1 = 1'b1; end
        @(negedge ref_clk);
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    // mode 0: plain frame; 1: offer 8'h01 mid-frame; 2: reset during data bit 3.
    task automatic check_frame(input logic [7:0] b, input int nstop, input int exp_arm,
                               input int mode, input string tag);
        int w = 0;
        int n = 0;
        int nbc = 0;
        int flen;
        int slot;
        logic want;
        logic [7:0] dec = '0;
        flen = (9 + nstop) * 64;
        while (m_out !== 1'b1 && w < 200) begin
            @(negedge ref_clk);
            w++;
        end
        chk({tag, " arm"}, w, exp_arm);
        while (m_busy && n < flen) begin
            if (m_bclk) nbc++;
            if (n % 64 == 32) begin
                slot = n / 64;
                want = (slot == 0) ? 1'b1 : (slot <= 8) ? ~b[slot-1] : 1'b0;
                chk($sformatf("%s slot%0d", tag, slot), m_out, want);
                if (slot >= 1 && slot <= 8) dec[slot-1] = ~m_out;
            end
            if (mode == 1 && n == 100) begin in1 = 8'h01; valid1 = 1'b1; end
            if (mode == 1 && n == 101) begin
                chk({tag, " ready mid"}, ready1, 1'b0);
                valid1 = 1'b0;
            end
            if (mode == 2 && n == 4 * 64 + 20) begin
                reset = 1'b1;
                @(negedge ref_clk);
                reset = 1'b0;
                chk({tag, " rst out"}, out1, 1'b0);
                chk({tag, " rst ready"}, ready1, 1'b1);
                chk({tag, " rst busy"}, busy1, 1'b0);
                return;
            end
            @(negedge ref_clk);
            n++;
        end
        chk({tag, " len"}, n, flen);
        chk({tag, " bclk"}, nbc, 10);
        chk({tag, " byte"}, dec, b);
`ifdef UART_TX_HOLD_EN
        if (mode == 1) begin
            chk({tag, " b2b busy"}, m_busy, 1'b1);
            chk({tag, " b2b out"}, m_out, 1'b1);
        end else begin
            chk({tag, " idle"}, m_busy, 1'b0);
        end
`else
        chk({tag, " idle"}, m_busy, 1'b0);
`endif
    endtask

    initial begin
        logic       bad;
        logic [7:0] lb [5];
        lb = '{8'h93, 8'h4D, 8'h12, 8'hAA, 8'h55};

        reset = 1'b1; valid1 = 1'b1; in1 = 8'hFF;
        bad = 1'b0;
        repeat (16) begin
            @(negedge ref_clk);
            if (bclk1 || out1) bad = 1'b1;
        end
        chk("rst out", out1, 1'b0);
        chk("rst ready", ready1, 1'b1);
        chk("rst busy", busy1, 1'b0);
        chk("rst quiet", bad, 1'b0);
        reset = 1'b0; valid1 = 1'b0;
        repeat (5) @(negedge ref_clk);

        send(8'hAC);
        check_frame(8'hAC, 1, 8, 0, "ac");

        for (int i = 0; i < 5; i++) begin
            send(lb[i]);
            check_frame(lb[i], 1, 8, 0, $sformatf("lb%0d", i));
        end

        send(8'h3C);
        check_frame(8'h3C, 1, 8, 1, "busy");
`ifdef UART_TX_HOLD_EN
        check_frame(8'h01, 1, 0, 0, "held");
`else
        bad = 1'b0;
        repeat (40) begin
            @(negedge ref_clk);
            if (out1 || busy1) bad = 1'b1;
        end
        chk("no accept", bad, 1'b0);
`endif

        send(8'hFF);
        check_frame(8'hFF, 1, 8, 2, "abort");
        repeat (3) @(negedge ref_clk);
        send(8'h5A);
        check_frame(8'h5A, 1, 8, 0, "after");

        sel = 1'b1;
        send(8'h00);
        check_frame(8'h00, 2, 8, 0, "stop2");
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
